carfield_preload_ctrl: RTL and testbench
========================================

CARFIELD_PRELOAD_CTRL -- requirements
Module: carfield_preload_ctrl

Interface
REQ-001 Parameter NumSrc, default 3, number of preload requesters (0=JTAG, 1=serial link, 2=UART) SHALL be supported.
REQ-002 Parameter TimeoutCycles, default 2**20, RUN-phase watchdog limit SHALL be supported.
REQ-003 clk_i  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_ni  in  1  reset SHALL be synchronous and active-low.
REQ-005 boot_mode_i  in  2  boot mode: 0 idle/preload, 1 SD (unsupported), 2-3 autonomous.
REQ-006 src_req_i / src_gnt_o  in/out  NumSrc each  per-source write request / grant.
REQ-007 src_addr_i, src_data_i  in  NumSrc x 32 each  per-source write address and data.
REQ-008 src_last_i  in  NumSrc  last beat of a source burst.
REQ-009 mem_req_o, mem_addr_o, mem_data_o / mem_gnt_i  out 1,32,32 / in 1  shared write port into boot memory.
REQ-010 launch_addr_i  in  32  address whose write ends preload and starts RUN.
REQ-011 scratch_we_i, scratch_wdata_i  in  1, 32  SoC scratch-register write observed in RUN.
REQ-012 eoc_o, exit_code_o, err_o, state_o  out  1, 31, 1, 3  end-of-computation, exit code, error, FSM state.

Function
REQ-013 FSM states SHALL be IDLE, PRELOAD, RUN, DONE, ERROR.
REQ-014 IDLE SHALL sample boot_mode_i on the first cycle after reset release: 0 -> PRELOAD, 1 -> ERROR, 2/3 -> RUN.
REQ-015 In PRELOAD, a round-robin arbiter SHALL grant one requesting source; pointer SHALL advance past the winner only when a beat with src_last_i is accepted.
REQ-016 Grant SHALL be locked to the winner until its last beat is accepted, even if other sources request.
REQ-017 mem_req_o, mem_addr_o, mem_data_o SHALL combinationally follow the locked source; src_gnt_o[i] SHALL equal mem_gnt_i AND lock==i.
REQ-018 Accepted beat with address == launch_addr_i SHALL move PRELOAD -> RUN on the next cycle, regardless of src_last_i; remaining requests SHALL be ignored thereafter.
REQ-019 In RUN, scratch_we_i with scratch_wdata_i[0]=1 SHALL set eoc_o and latch exit_code_o = scratch_wdata_i[31:1] one cycle later; FSM -> DONE.
REQ-020 DONE and ERROR SHALL be terminal until reset; src_gnt_o and mem_req_o SHALL be 0 outside PRELOAD.
REQ-021 Simultaneous requests at pointer position: lowest index at or after pointer SHALL win.
REQ-022 ERROR SHALL assert err_o=1 and eoc_o=1, exit_code_o=31'h7FFF_FFFF.

Reset
REQ-023 While rst_ni=0 (sampled at edge): state IDLE, pointer 0, lock cleared, eoc_o=0, err_o=0, exit_code_o=0, watchdog 0.
REQ-024 Reset asserted mid-burst SHALL drop mem_req_o the following cycle with no partial-state retention.

Configuration
REQ-025 With CARFIELD_PRELOAD_TIMEOUT_EN defined, a RUN-phase counter SHALL move RUN -> ERROR when it reaches TimeoutCycles without EOC.
REQ-026 Without CARFIELD_PRELOAD_TIMEOUT_EN, no counter SHALL be instantiated and RUN SHALL wait indefinitely.

Structure
REQ-027 State enum, source-index constants and ERROR exit code SHALL reside in carfield_pkg.
REQ-028 Round-robin lock arbiter SHALL be sub-module carfield_preload_rr_arb; FSM and EOC logic in top.

Verification
REQ-029 boot_mode 0, JTAG writes 4 beats (last on 4th), then launch address -> 5 grants, state RUN next cycle.
REQ-030 JTAG and UART request together, pointer 0, 2-beat bursts -> JTAG beats 1-2 granted, then UART; no interleave.
REQ-031 RUN, scratch write 32'h0000_0001 -> eoc_o=1, exit_code_o=0; write 32'h0000_0007 in a fresh run -> exit_code_o=3.
REQ-032 boot_mode 1 -> ERROR, err_o=1, exit_code_o=31'h7FFF_FFFF within 2 cycles of reset release.
REQ-033 TIMEOUT_EN, TimeoutCycles=16, no scratch write -> ERROR at RUN cycle 16; without macro -> still RUN at cycle 1000.
REQ-034 Reset asserted during serial-link beat 2 with mem_gnt_i=0 -> mem_req_o=0 next cycle, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/carfield_pkg.sv
// Shared types and constants for the Carfield boot-memory preload controller.
package carfield_pkg;

  // FSM state encoding, also exported on state_o
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // Preload requester indices
  localparam int unsigned SRC_JTAG  = 0;
  localparam int unsigned SRC_SLINK = 1;
  localparam int unsigned SRC_UART  = 2;

  // Boot mode encodings
  localparam logic [1:0] BOOT_PRELOAD = 2'd0;
  localparam logic [1:0] BOOT_SD      = 2'd1;

  // Exit code reported when the controller ends in ERROR
  localparam logic [30:0] EXIT_CODE_ERR = 31'h7FFF_FFFF;

endpackage

// File: rtl/carfield_preload_rr_arb.sv
// Round-robin arbiter with burst lock for the preload write port.
// A source is locked from the first cycle it is presented until its last
// beat is accepted; only then does the pointer move past it.
module carfield_preload_rr_arb #(
  parameter int unsigned NumSrc = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [NumSrc-1:0] req_i,
  input  logic [NumSrc-1:0] last_i,
  input  logic              gnt_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              req_o,
  output logic [NumSrc-1:0] gnt_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSrc - 1);

  logic            locked_q;
  logic [IdxW-1:0] lock_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] sel;
  logic            active;
  logic            accept;

  // Lowest requesting index at or after the pointer, wrapping around
  always_comb begin : pick_next
    int unsigned cand;
    logic        found;
    cand  = 0;
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned k = 0; k < NumSrc; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NumSrc) cand = cand - NumSrc;
      if (!found && req_i[IdxW'(cand)]) begin
        pick  = IdxW'(cand);
        found = 1'b1;
      end
    end
  end

  // Route the locked (or freshly picked) source to the memory port
  always_comb begin
    sel    = locked_q ? lock_q : pick;
    active = en_i & (locked_q | (|req_i));
    req_o  = active & req_i[sel];
    accept = req_o & gnt_i;
    idx_o  = sel;
    gnt_o  = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (accept && (sel == IdxW'(i))) gnt_o[i] = 1'b1;
    end
  end

  // Lock and pointer bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      locked_q <= 1'b0;
      lock_q   <= '0;
      ptr_q    <= '0;
    end else if (flush_i) begin
      locked_q <= 1'b0;
    end else if (active) begin
      if (accept && last_i[sel]) begin
        locked_q <= 1'b0;
        ptr_q    <= (sel == LastIdx) ? '0 : sel + 1'b1;
      end else begin
        locked_q <= 1'b1;
        lock_q   <= sel;
      end
    end
  end

endmodule

// File: rtl/carfield_preload_ctrl.sv
// Carfield boot preload controller: arbitrates preload sources into boot
// memory, starts RUN on a write to the launch address and reports
// end-of-computation from the SoC scratch register.
// Optional RUN watchdog: define CARFIELD_PRELOAD_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, samples boot_mode_i on the first cycle
// PRELOAD | sources write boot memory until the launch address hits
// RUN     | program executing, waiting for a scratch EOC write
// DONE    | EOC seen, exit code latched; held until reset
// ERROR   | unsupported boot mode or watchdog expiry; held until reset
module carfield_preload_ctrl
  import carfield_pkg::*;
#(
  parameter int unsigned NumSrc        = 3,
  parameter int unsigned TimeoutCycles = 2**20
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             boot_mode_i,
  input  logic [NumSrc-1:0]      src_req_i,
  output logic [NumSrc-1:0]      src_gnt_o,
  input  logic [NumSrc-1:0][31:0] src_addr_i,
  input  logic [NumSrc-1:0][31:0] src_data_i,
  input  logic [NumSrc-1:0]      src_last_i,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  input  logic                   mem_gnt_i,
  input  logic [31:0]            launch_addr_i,
  input  logic                   scratch_we_i,
  input  logic [31:0]            scratch_wdata_i,
  output logic                   eoc_o,
  output logic [30:0]            exit_code_o,
  output logic                   err_o,
  output logic [2:0]             state_o
);

  localparam int unsigned IdxW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  state_e          state_q, state_d;
  logic            eoc_q;
  logic [30:0]     exit_code_q;
  logic            preload_en;
  logic [IdxW-1:0] arb_idx;
  logic            launch_hit;
  logic            eoc_hit;
  logic            wdog_expired;

  assign preload_en = (state_q == ST_PRELOAD);
  assign launch_hit = mem_req_o & mem_gnt_i & (mem_addr_o == launch_addr_i);
  assign eoc_hit    = scratch_we_i & scratch_wdata_i[0];
  assign mem_addr_o = src_addr_i[arb_idx];
  assign mem_data_o = src_data_i[arb_idx];

  carfield_preload_rr_arb #(
    .NumSrc (NumSrc),
    .IdxW   (IdxW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (preload_en),
    .flush_i (launch_hit),
    .req_i   (src_req_i),
    .last_i  (src_last_i),
    .gnt_i   (mem_gnt_i),
    .idx_o   (arb_idx),
    .req_o   (mem_req_o),
    .gnt_o   (src_gnt_o)
  );

`ifdef CARFIELD_PRELOAD_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wdog_q;

  // Count cycles spent in RUN; cleared everywhere else
  always_ff @(posedge clk_i) begin
    if (!rst_ni || (state_q != ST_RUN)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_expired = (wdog_q == WdW'(TimeoutCycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign wdog_expired       = 1'b0;
`endif

  // State register plus EOC / exit-code capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      eoc_q       <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_RUN) && eoc_hit) begin
        eoc_q       <= 1'b1;
        exit_code_q <= scratch_wdata_i[31:1];
      end
    end
  end

  // Next-state decision; EOC wins over a coincident watchdog expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (boot_mode_i == BOOT_PRELOAD)  state_d = ST_PRELOAD;
        else if (boot_mode_i == BOOT_SD)  state_d = ST_ERROR;
        else                              state_d = ST_RUN;
      end
      ST_PRELOAD: if (launch_hit) state_d = ST_RUN;
      ST_RUN: begin
        if (eoc_hit)           state_d = ST_DONE;
        else if (wdog_expired) state_d = ST_ERROR;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Status outputs; ERROR forces its fixed report
  always_comb begin
    err_o       = (state_q == ST_ERROR);
    eoc_o       = eoc_q | err_o;
    exit_code_o = err_o ? EXIT_CODE_ERR : exit_code_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_carfield_preload_ctrl.sv
// Directed bench for carfield_preload_ctrl (NumSrc=3, TimeoutCycles=16).
module tb_carfield_preload_ctrl;
  import carfield_pkg::*;

  logic             clk_i;
  logic             rst_ni;
  logic [1:0]       boot_mode_i;
  logic [2:0]       src_req_i;
  logic [2:0]       src_gnt_o;
  logic [2:0][31:0] src_addr_i;
  logic [2:0][31:0] src_data_i;
  logic [2:0]       src_last_i;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic             mem_gnt_i;
  logic [31:0]      launch_addr_i;
  logic             scratch_we_i;
  logic [31:0]      scratch_wdata_i;
  logic             eoc_o;
  logic [30:0]      exit_code_o;
  logic             err_o;
  logic [2:0]       state_o;

  int n_cmp = 0;
  int n_mis = 0;

  carfield_preload_ctrl #(
    .NumSrc        (3),
    .TimeoutCycles (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .boot_mode_i     (boot_mode_i),
    .src_req_i       (src_req_i),
    .src_gnt_o       (src_gnt_o),
    .src_addr_i      (src_addr_i),
    .src_data_i      (src_data_i),
    .src_last_i      (src_last_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_gnt_i       (mem_gnt_i),
    .launch_addr_i   (launch_addr_i),
    .scratch_we_i    (scratch_we_i),
    .scratch_wdata_i (scratch_wdata_i),
    .eoc_o           (eoc_o),
    .exit_code_o     (exit_code_o),
    .err_o           (err_o),
    .state_o         (state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 2 time units after the edge
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    src_req_i       = '0;
    src_last_i      = '0;
    src_addr_i      = '0;
    src_data_i      = '0;
    mem_gnt_i       = 1'b0;
    scratch_we_i    = 1'b0;
    scratch_wdata_i = '0;
  endtask

  // Reset for two cycles, then release; returns after the IDLE decision edge
  task automatic do_reset(input logic [1:0] mode);
    rst_ni      = 1'b0;
    boot_mode_i = mode;
    clear_inputs();
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] last;
    logic       gnt;
    int         win;   // expected winner, 3 = none
  } vec_t;

  vec_t vecs[9];
  int   n_gnt;
  logic [31:0] exp_addr;
  logic [2:0]  exp_gnt;

  initial begin
    launch_addr_i = 32'h0000_8000;
    rst_ni        = 1'b0;
    boot_mode_i   = 2'd0;
    clear_inputs();

    // Reset state
    step();
    step();
    check_eq("rst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("rst_eoc", 32'(eoc_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    check_eq("rst_exit", 32'(exit_code_o), 0);
    check_eq("rst_mem_req", 32'(mem_req_o), 0);

    // JTAG preload: 4-beat burst then launch beat
    rst_ni = 1'b1;
    step();
    check_eq("pl_state", 32'(state_o), 32'(ST_PRELOAD));
    n_gnt     = 0;
    mem_gnt_i = 1'b1;
    for (int b = 0; b < 5; b++) begin
      src_req_i  = 3'b001;
      src_addr_i[SRC_JTAG] = (b == 4) ? 32'h0000_8000 : 32'h0000_1000 + 32'(b * 4);
      src_data_i[SRC_JTAG] = 32'hA000_0000 + 32'(b);
      src_last_i = (b >= 3) ? 3'b001 : 3'b000;
      #1;
      check_eq($sformatf("pl_addr_b%0d", b), mem_addr_o, src_addr_i[SRC_JTAG]);
      if (b == 0) check_eq("pl_data_b0", mem_data_o, 32'hA000_0000);
      n_gnt += int'(src_gnt_o[SRC_JTAG]);
      step();
    end
    check_eq("pl_grants", 32'(n_gnt), 5);
    check_eq("pl_run", 32'(state_o), 32'(ST_RUN));
    #1;
    check_eq("run_ignore_req", 32'(mem_req_o), 0);
    check_eq("run_ignore_gnt", 32'(src_gnt_o), 0);
    clear_inputs();

    // EOC with exit code 0, then DONE is terminal
    scratch_we_i    = 1'b1;
    scratch_wdata_i = 32'h0000_0001;
    step();
    scratch_we_i = 1'b0;
    check_eq("eoc1_eoc", 32'(eoc_o), 1);
    check_eq("eoc1_exit", 32'(exit_code_o), 0);
    check_eq("eoc1_state", 32'(state_o), 32'(ST_DONE));
    scratch_we_i    = 1'b1;
    scratch_wdata_i = 32'h0000_0007;
    step();
    scratch_we_i = 1'b0;
    check_eq("done_hold_exit", 32'(exit_code_o), 0);
    check_eq("done_hold_state", 32'(state_o), 32'(ST_DONE));

    // Arbitration vectors: addr of source i in cycle c is 0x1000*(i+1)+c
    vecs[0] = '{3'b101, 3'b000, 1'b1, 0};  // JTAG beat1, UART waits
    vecs[1] = '{3'b101, 3'b001, 1'b0, 0};  // stall, still JTAG
    vecs[2] = '{3'b101, 3'b001, 1'b1, 0};  // JTAG last, ptr -> 1
    vecs[3] = '{3'b100, 3'b000, 1'b1, 2};  // UART beat1
    vecs[4] = '{3'b110, 3'b100, 1'b1, 2};  // slink at ptr, UART keeps lock
    vecs[5] = '{3'b011, 3'b011, 1'b1, 0};  // ptr 0: JTAG over slink
    vecs[6] = '{3'b011, 3'b010, 1'b1, 1};  // ptr 1: slink
    vecs[7] = '{3'b101, 3'b101, 1'b1, 2};  // ptr 2: UART over JTAG
    vecs[8] = '{3'b000, 3'b000, 1'b1, 3};  // nothing requested
    do_reset(2'd0);
    for (int c = 0; c < 9; c++) begin
      src_req_i  = vecs[c].req;
      src_last_i = vecs[c].last;
      mem_gnt_i  = vecs[c].gnt;
      for (int i = 0; i < 3; i++) src_addr_i[i] = 32'h1000 * 32'(i + 1) + 32'(c);
      exp_addr = 32'h1000 * 32'(vecs[c].win + 1) + 32'(c);
      exp_gnt  = (vecs[c].win != 3 && vecs[c].gnt) ? 3'(1 << vecs[c].win) : 3'b000;
      #1;
      check_eq($sformatf("arb_c%0d_req", c), 32'(mem_req_o), (vecs[c].win != 3) ? 1 : 0);
      if (vecs[c].win != 3) check_eq($sformatf("arb_c%0d_addr", c), mem_addr_o, exp_addr);
      check_eq($sformatf("arb_c%0d_gnt", c), 32'(src_gnt_o), 32'(exp_gnt));
      step();
    end
    check_eq("arb_still_preload", 32'(state_o), 32'(ST_PRELOAD));
    clear_inputs();

    // Autonomous boot: bit0=0 write ignored, then exit code 3
    do_reset(2'd2);
    check_eq("auto_state", 32'(state_o), 32'(ST_RUN));
    scratch_we_i    = 1'b1;
    scratch_wdata_i = 32'h0000_0006;
    step();
    check_eq("nobit0_eoc", 32'(eoc_o), 0);
    check_eq("nobit0_state", 32'(state_o), 32'(ST_RUN));
    scratch_wdata_i = 32'h0000_0007;
    step();
    scratch_we_i = 1'b0;
    check_eq("eoc3_eoc", 32'(eoc_o), 1);
    check_eq("eoc3_exit", 32'(exit_code_o), 3);
    check_eq("eoc3_state", 32'(state_o), 32'(ST_DONE));

    // SD boot mode -> ERROR
    do_reset(2'd1);
    src_req_i = 3'b111;
    mem_gnt_i = 1'b1;
    #1;
    check_eq("sd_state", 32'(state_o), 32'(ST_ERROR));
    check_eq("sd_err", 32'(err_o), 1);
    check_eq("sd_eoc", 32'(eoc_o), 1);
    check_eq("sd_exit", 32'(exit_code_o), 32'h7FFF_FFFF);
    check_eq("sd_mem_req", 32'(mem_req_o), 0);
    check_eq("sd_gnt", 32'(src_gnt_o), 0);

    // RUN watchdog
    do_reset(2'd3);
    check_eq("wd_run", 32'(state_o), 32'(ST_RUN));
`ifdef CARFIELD_PRELOAD_TIMEOUT_EN
    for (int k = 0; k < 15; k++) step();
    check_eq("wd_cycle15", 32'(state_o), 32'(ST_RUN));
    step();
    check_eq("wd_cycle16", 32'(state_o), 32'(ST_ERROR));
    check_eq("wd_exit", 32'(exit_code_o), 32'h7FFF_FFFF);
`else
    for (int k = 0; k < 1000; k++) step();
    check_eq("wd_none_1000", 32'(state_o), 32'(ST_RUN));
    check_eq("wd_none_err", 32'(err_o), 0);
`endif

    // Reset mid-burst on the serial link
    do_reset(2'd0);
    src_req_i  = 3'b010;
    src_addr_i[SRC_SLINK] = 32'h0000_2000;
    mem_gnt_i  = 1'b1;
    step();
    src_addr_i[SRC_SLINK] = 32'h0000_2004;
    mem_gnt_i  = 1'b0;
    #1;
    check_eq("mid_beat2_req", 32'(mem_req_o), 1);
    check_eq("mid_beat2_addr", mem_addr_o, 32'h0000_2004);
    rst_ni = 1'b0;
    step();
    check_eq("mid_rst_req", 32'(mem_req_o), 0);
    check_eq("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
    check_eq("mid_rst_eoc", 32'(eoc_o), 0);
    check_eq("mid_rst_err", 32'(err_o), 0);
    check_eq("mid_rst_exit", 32'(exit_code_o), 0);
    rst_ni    = 1'b1;
    src_req_i = 3'b011;
    src_addr_i[SRC_JTAG] = 32'h0000_3000;
    mem_gnt_i = 1'b1;
    step();
    #1;
    check_eq("post_rst_state", 32'(state_o), 32'(ST_PRELOAD));
    check_eq("post_rst_addr", mem_addr_o, 32'h0000_3000);
    check_eq("post_rst_gnt", 32'(src_gnt_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
